// File: rtl/hsv_core_pkg.sv
// Shared types for the hsv core writeback path: unit ids, writeback payload,
// and the register one-hot helper used for commit masks.
package hsv_core_pkg;

  localparam int HSV_NUM_WB_UNITS = 5;

  typedef logic [4:0]  reg_addr;
  typedef logic [31:0] word;

  typedef struct packed {
    reg_addr rd_addr;
    word     value;
  } wb_data_t;

  typedef enum logic [2:0] {
    WB_ALU         = 3'd0,
    WB_FOO         = 3'd1,
    WB_MEM         = 3'd2,
    WB_BRANCH      = 3'd3,
    WB_CTRL_STATUS = 3'd4
  } wb_unit_e;

  // x0 is hardwired, so it never appears in a commit mask
  function automatic logic [31:0] reg_onehot(reg_addr a);
    return (a == '0) ? 32'd0 : (32'd1 << a);
  endfunction

endpackage

// File: rtl/hsv_core_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// otherwise the lowest requester below ptr.
module hsv_core_rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    // upper pass covers ptr..N-1, lower pass provides the wrap to 0..ptr-1
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    gnt = found ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/hsv_core_wb_arbiter.sv
// Writeback arbiter sharing the register-file write port among execution units.
// Optional per-unit one-entry skid buffers are built when HSV_WB_ARB_SKID_EN is defined.
module hsv_core_wb_arbiter
  import hsv_core_pkg::*;
#(
  parameter int NUM_UNITS = HSV_NUM_WB_UNITS
) (
  input  logic                      clk_core,
  input  logic                      rst_core,
  input  logic                      flush_req,
  output logic                      flush_ack,
  input  logic [NUM_UNITS-1:0]      unit_valid_i,
  output logic [NUM_UNITS-1:0]      unit_ready_o,
  input  wb_data_t [NUM_UNITS-1:0]  unit_data,
  output logic                      wr_en,
  output reg_addr                   wr_addr,
  output word                       wr_data,
  output logic [31:0]               commit_mask
);

  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [PW-1:0]        ptr;
  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_any;
  wb_data_t             gnt_data;

  hsv_core_rr_arbiter #(.N(NUM_UNITS), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt;

`ifdef HSV_WB_ARB_SKID_EN
  logic [NUM_UNITS-1:0]     skid_vld;
  wb_data_t [NUM_UNITS-1:0] skid_data;
  wb_data_t [NUM_UNITS-1:0] cand_data;

  assign req          = (skid_vld | unit_valid_i) & {NUM_UNITS{~flush_req}};
  assign unit_ready_o = ~skid_vld & {NUM_UNITS{~(flush_req | rst_core)}};

  // a parked entry shadows the live input of the same unit
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_cand
    assign cand_data[i] = skid_vld[i] ? skid_data[i] : unit_data[i];
  end
  assign gnt_data = cand_data[gnt_idx];

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      skid_vld  <= '0;
      skid_data <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (flush_req) begin
          skid_vld[i] <= 1'b0;
        end else if (skid_vld[i]) begin
          if (gnt[i]) skid_vld[i] <= 1'b0;
        end else if (unit_valid_i[i] && !gnt[i]) begin
          skid_vld[i]  <= 1'b1;
          skid_data[i] <= unit_data[i];
        end
      end
    end
  end
`else
  assign req          = unit_valid_i & {NUM_UNITS{~flush_req}};
  assign unit_ready_o = gnt & {NUM_UNITS{~rst_core}};
  assign gnt_data     = unit_data[gnt_idx];
`endif

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      ptr         <= '0;
      flush_ack   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit_mask <= '0;
    end else begin
      flush_ack <= flush_req;
      if (flush_req)
        ptr <= '0;
      else if (gnt_any)
        ptr <= (gnt_idx == PW'(NUM_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
      wr_en       <= gnt_any && (gnt_data.rd_addr != '0);
      commit_mask <= gnt_any ? reg_onehot(gnt_data.rd_addr) : 32'd0;
      // address/data keep their last value on idle cycles
      if (gnt_any) begin
        wr_addr <= gnt_data.rd_addr;
        wr_data <= gnt_data.value;
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_wb_arbiter.sv
// Self-checking bench for hsv_core_wb_arbiter: directed scenarios plus a
// randomized phase compared every cycle against a round-robin reference model.
module tb_hsv_core_wb_arbiter;
  import hsv_core_pkg::*;

  localparam int N = HSV_NUM_WB_UNITS;

  logic             clk_core = 1'b0;
  logic             rst_core = 1'b1;
  logic             flush_req = 1'b0;
  logic             flush_ack;
  logic [N-1:0]     unit_valid_i = '0;
  logic [N-1:0]     unit_ready_o;
  wb_data_t [N-1:0] unit_data = '0;
  logic             wr_en;
  reg_addr          wr_addr;
  word              wr_data;
  logic [31:0]      commit_mask;

  int checks = 0;
  int errors = 0;

  hsv_core_wb_arbiter #(.NUM_UNITS(N)) dut (
    .clk_core     (clk_core),
    .rst_core     (rst_core),
    .flush_req    (flush_req),
    .flush_ack    (flush_ack),
    .unit_valid_i (unit_valid_i),
    .unit_ready_o (unit_ready_o),
    .unit_data    (unit_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit_mask  (commit_mask)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr, m_hs, exp_g;
  logic        m_wr_en, m_ack;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data, m_mask;
  wb_data_t    g_data;

  task automatic model_reset();
    m_ptr = 0; m_hs = -1; m_wr_en = 1'b0; m_ack = 1'b0;
    m_wr_addr = '0; m_wr_data = '0; m_mask = '0;
  endtask

  function automatic bit vbit(int u);
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (i == u) r = unit_valid_i[i];
    return r;
  endfunction

  function automatic wb_data_t dsel(int u);
    wb_data_t r = '0;
    for (int i = 0; i < N; i++) if (i == u) r = unit_data[i];
    return r;
  endfunction

  initial begin : compare
    logic [N-1:0] exp_rdy;
    model_reset();
    forever begin
      @(negedge clk_core);
      exp_g = -1;
      if (rst_core) model_reset();
      else if (!flush_req)
        for (int k = 0; k < N; k++)
          if (exp_g < 0 && vbit((m_ptr + k) % N)) exp_g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (exp_g >= 0) begin
        exp_rdy = N'(1) << exp_g;
        g_data  = dsel(exp_g);
      end
      chk("ready",       32'(unit_ready_o), 32'(exp_rdy));
      chk("wr_en",       32'(wr_en),        32'(m_wr_en));
      chk("wr_addr",     32'(wr_addr),      32'(m_wr_addr));
      chk("wr_data",     wr_data,           m_wr_data);
      chk("commit_mask", commit_mask,       m_mask);
      chk("flush_ack",   32'(flush_ack),    32'(m_ack));
      @(posedge clk_core);
      if (rst_core) model_reset();
      else begin
        m_hs = exp_g;
        if (exp_g >= 0) begin
          m_wr_addr = g_data.rd_addr;
          m_wr_data = g_data.value;
          m_wr_en   = (g_data.rd_addr != 0);
          m_mask    = (g_data.rd_addr == 0) ? 32'd0 : (32'd1 << g_data.rd_addr);
          m_ptr     = (exp_g + 1) % N;
        end else begin
          m_wr_en = 1'b0;
          m_mask  = 32'd0;
        end
        if (flush_req) m_ptr = 0;
        m_ack = flush_req;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_core); #2;
    for (int i = 0; i < N; i++) if (m_hs == i) unit_valid_i[i] = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_core = 1'b1;
    unit_valid_i = '0;
    flush_req    = 1'b0;
    repeat (2) @(posedge clk_core);
    #2 rst_core = 1'b0;
  endtask

  initial begin : main
    logic [31:0] masks [5];
    masks = '{32'h2, 32'h4, 32'h8, 32'h10, 32'h20};

    // reset state
    @(negedge clk_core);
    chk("rst_ready", 32'(unit_ready_o), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_mask",  commit_mask, 32'h0);
    chk("rst_ack",   32'(flush_ack), 32'h0);
    do_reset();

    // single alu write
    unit_valid_i[0] = 1'b1;
    unit_data[0]    = '{rd_addr: 5'd5, value: 32'hDEADBEEF};
    cyc();
    @(negedge clk_core);
    chk("alu_wr_en", 32'(wr_en), 32'h1);
    chk("alu_addr",  32'(wr_addr), 32'h5);
    chk("alu_data",  wr_data, 32'hDEADBEEF);
    chk("alu_mask",  commit_mask, 32'h20);
    do_reset();

    // all units contend: strict rotation from alu
    for (int i = 0; i < N; i++) begin
      unit_valid_i[i] = 1'b1;
      unit_data[i]    = '{rd_addr: 5'(i + 1), value: 32'h1000 + 32'(i)};
    end
    for (int k = 0; k < N; k++) begin
      cyc();
      @(negedge clk_core);
      chk("rot_mask", commit_mask, masks[k]);
      chk("rot_addr", 32'(wr_addr), 32'(k + 1));
    end
    cyc();
    @(negedge clk_core);
    chk("rot_idle", 32'(wr_en), 32'h0);

    // x0 destination is consumed but not written
    cyc();
    unit_valid_i[2] = 1'b1;
    unit_data[2]    = '{rd_addr: 5'd0, value: 32'h0BADF00D};
    @(negedge clk_core);
    chk("x0_ready", 32'(unit_ready_o), 32'h4);
    cyc();
    @(negedge clk_core);
    chk("x0_wr_en", 32'(wr_en), 32'h0);
    chk("x0_mask",  commit_mask, 32'h0);

    // flush resets the pointer (foo grant leaves it at mem first)
    cyc();
    unit_valid_i[1] = 1'b1;
    unit_data[1]    = '{rd_addr: 5'd7, value: 32'h77};
    cyc();
    unit_valid_i[0] = 1'b1;
    unit_data[0]    = '{rd_addr: 5'd9, value: 32'h99};
    unit_valid_i[3] = 1'b1;
    unit_data[3]    = '{rd_addr: 5'd10, value: 32'hAA};
    flush_req = 1'b1;
    @(negedge clk_core);
    chk("fl_ready0", 32'(unit_ready_o), 32'h0);
    cyc();
    @(negedge clk_core);
    chk("fl_ack1", 32'(flush_ack), 32'h1);
    chk("fl_ready1", 32'(unit_ready_o), 32'h0);
    cyc();
    flush_req = 1'b0;
    @(negedge clk_core);
    chk("fl_ack2",  32'(flush_ack), 32'h1);
    chk("fl_alu_first", 32'(unit_ready_o), 32'h1);
    cyc();
    @(negedge clk_core);
    chk("fl_ack3", 32'(flush_ack), 32'h0);
    chk("fl_addr", 32'(wr_addr), 32'h9);
    chk("fl_mask", commit_mask, 32'h200);
    cyc();
    cyc();

    // asynchronous reset mid-stream
    unit_valid_i[0] = 1'b1;
    unit_data[0]    = '{rd_addr: 5'd3, value: 32'h33};
    @(posedge clk_core); #2;
    chk("ar_pre_wr_en", 32'(wr_en), 32'h1);
    #1 rst_core = 1'b1;
    #1;
    chk("ar_wr_en", 32'(wr_en), 32'h0);
    chk("ar_mask",  commit_mask, 32'h0);
    chk("ar_ready", 32'(unit_ready_o), 32'h0);
    unit_valid_i = '0;
    repeat (2) @(posedge clk_core);
    #2 rst_core = 1'b0;

    // randomized traffic with occasional flushes
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_core); #2;
      for (int i = 0; i < N; i++) begin
        if (unit_valid_i[i] && m_hs == i) begin
          unit_valid_i[i] = 1'($urandom_range(0, 1));
          unit_data[i]    = '{rd_addr: 5'($urandom), value: $urandom};
        end else if (!unit_valid_i[i] && $urandom_range(0, 3) == 0) begin
          unit_valid_i[i] = 1'b1;
          unit_data[i]    = '{rd_addr: 5'($urandom), value: $urandom};
        end
      end
      flush_req = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk_core); #2;
    flush_req    = 1'b0;
    unit_valid_i = '0;
    repeat (2) @(negedge clk_core);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
